// File: rtl/bow_tx_apb_arbiter.sv
// bow_tx_apb_arbiter
// Round-robin arbiter and APB master sequencer for the BoW TX APB port.
// Two requesters share one APB write interface. Each accepted word runs
// through a SETUP/ACCESS cycle, waits for pready, and is aborted with a
// one-cycle timeout_err pulse if pready does not arrive in time.
// All APB and sideband outputs are registered; rN_ready is combinational.

module bow_tx_apb_arbiter #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic              txclk,
  input  logic              presetn,
  input  logic              enable,

  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r0_fec,
  input  logic              r0_aux,

  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_data,
  input  logic              r1_fec,
  input  logic              r1_aux,

  output logic              psel_tx,
  output logic              penable_tx,
  output logic              pwrite_tx,
  output logic [DATA_W-1:0] pwdata_tx,
  output logic              fec_out,
  output logic              aux_out,
  input  logic              pready,

  output logic              busy,
  output logic              grant_id,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // TIMEOUT is at most 255, so an 8-bit wait counter always suffices.
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_lastGrant;
  logic [7:0]  r_waitCnt;

  logic        w_pick;
  logic        w_grantWindow;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;

  // Round-robin pick: prefer the requester that did not win last time.
  always_comb begin
    w_pick = 1'b0;
    if (r_lastGrant) begin
      w_pick = r0_valid ? 1'b0 : 1'b1;
    end else begin
      w_pick = r1_valid ? 1'b1 : 1'b0;
    end
  end

  // Only IDLE with enable high may hand out a grant; the pick makes the readies one-hot.
  always_comb begin
    w_grantWindow = enable && (r_state == IDLE);
    r0_ready      = w_grantWindow && r0_valid && (w_pick == 1'b0);
    r1_ready      = w_grantWindow && r1_valid && (w_pick == 1'b1);
    w_accept      = r0_ready || r1_ready;
  end

  // ACCESS ends on pready, or on the last allowed wait cycle without it (pready wins a tie).
  always_comb begin
    w_done    = (r_state == ACCESS) && pready;
    w_timeout = (r_state == ACCESS) && !pready && (r_waitCnt == LP_WAIT_LAST);
  end

  // Next-state logic for the IDLE -> SETUP -> ACCESS sequencer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_nextState = ACCESS;
      end
      ACCESS: begin
        if (w_done || w_timeout) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset drops the FSM straight back to IDLE.
  always_ff @(posedge txclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // APB strobes follow the next state so they change in the same cycle the state does.
  always_ff @(posedge txclk or negedge presetn) begin
    if (!presetn) begin
      psel_tx    <= 1'b0;
      penable_tx <= 1'b0;
      pwrite_tx  <= 1'b0;
    end else begin
      psel_tx    <= (w_nextState != IDLE);
      penable_tx <= (w_nextState == ACCESS);
      pwrite_tx  <= (w_nextState != IDLE);
    end
  end

  // Capture the winning word and sidebands at the handshake; they hold until the next accept.
  always_ff @(posedge txclk or negedge presetn) begin
    if (!presetn) begin
      pwdata_tx   <= '0;
      fec_out     <= 1'b0;
      aux_out     <= 1'b0;
      grant_id    <= 1'b0;
      r_lastGrant <= 1'b1;
    end else if (w_accept) begin
      grant_id    <= w_pick;
      r_lastGrant <= w_pick;
      if (w_pick) begin
        pwdata_tx <= r1_data;
        fec_out   <= r1_fec;
        aux_out   <= r1_aux;
      end else begin
        pwdata_tx <= r0_data;
        fec_out   <= r0_fec;
        aux_out   <= r0_aux;
      end
    end
  end

  // Wait counter counts ACCESS cycles and sits at zero everywhere else.
  always_ff @(posedge txclk or negedge presetn) begin
    if (!presetn) begin
      r_waitCnt <= '0;
    end else if ((r_state == ACCESS) && (w_nextState == ACCESS)) begin
      r_waitCnt <= r_waitCnt + 8'd1;
    end else begin
      r_waitCnt <= '0;
    end
  end

  // Completion counter (free-running wrap) and the one-cycle abort pulse.
  always_ff @(posedge txclk or negedge presetn) begin
    if (!presetn) begin
      xfer_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= w_timeout;
      if (w_done) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_bow_tx_apb_arbiter.sv
// tb_bow_tx_apb_arbiter
// Directed bench for the BoW TX APB arbiter: table-driven arbitration and
// transfer vectors plus hand-written sequences for timeout, reset, enable
// and counter wrap. CNT_W is reduced so the wrap is reachable quickly.

module tb_bow_tx_apb_arbiter;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic              txclk    = 1'b0;
  logic              presetn  = 1'b0;
  logic              enable   = 1'b0;
  logic              r0_valid = 1'b0;
  logic              r0_ready;
  logic [DATA_W-1:0] r0_data  = '0;
  logic              r0_fec   = 1'b0;
  logic              r0_aux   = 1'b0;
  logic              r1_valid = 1'b0;
  logic              r1_ready;
  logic [DATA_W-1:0] r1_data  = '0;
  logic              r1_fec   = 1'b0;
  logic              r1_aux   = 1'b0;
  logic              psel_tx;
  logic              penable_tx;
  logic              pwrite_tx;
  logic [DATA_W-1:0] pwdata_tx;
  logic              fec_out;
  logic              aux_out;
  logic              pready   = 1'b0;
  logic              busy;
  logic              grant_id;
  logic              timeout_err;
  logic [CNT_W-1:0]  xfer_cnt;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] expCnt = '0;

  typedef struct {
    logic en;
    logic v0;
    logic v1;
    logic expR0;
    logic expR1;
  } arbVec_t;

  typedef struct {
    logic              req;
    logic [DATA_W-1:0] data;
    logic              fec;
    logic              aux;
    logic              expGrant;
  } xferVec_t;

  arbVec_t  arbTab[6];
  xferVec_t xferTab[4];

  bow_tx_apb_arbiter #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .txclk      (txclk),
    .presetn    (presetn),
    .enable     (enable),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_data    (r0_data),
    .r0_fec     (r0_fec),
    .r0_aux     (r0_aux),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_data    (r1_data),
    .r1_fec     (r1_fec),
    .r1_aux     (r1_aux),
    .psel_tx    (psel_tx),
    .penable_tx (penable_tx),
    .pwrite_tx  (pwrite_tx),
    .pwdata_tx  (pwdata_tx),
    .fec_out    (fec_out),
    .aux_out    (aux_out),
    .pready     (pready),
    .busy       (busy),
    .grant_id   (grant_id),
    .timeout_err(timeout_err),
    .xfer_cnt   (xfer_cnt)
  );

  // Free-running 10 ns clock.
  always #5 txclk = ~txclk;

  // Hard stop if something wedges the main sequence.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    presetn  = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    enable   = 1'b1;
    pready   = 1'b1;
    @(posedge txclk); #1;
    @(posedge txclk); #1;
    presetn = 1'b1;
    expCnt  = '0;
    @(posedge txclk); #1;
  endtask

  // One single-requester word with pready high; called just after a rising edge in IDLE.
  task automatic applyStimulus(input logic req, input logic [DATA_W-1:0] data,
                               input logic fec, input logic aux, input logic expGrant);
    pready = 1'b1;
    if (!req) begin
      r0_valid = 1'b1; r0_data = data; r0_fec = fec; r0_aux = aux;
    end else begin
      r1_valid = 1'b1; r1_data = data; r1_fec = fec; r1_aux = aux;
    end
    #1;
    checkOutput("xfer_req_ready", 32'(req ? r1_ready : r0_ready), 1);
    checkOutput("xfer_other_ready", 32'(req ? r0_ready : r1_ready), 0);
    @(posedge txclk); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    r0_data = ~data; r1_data = ~data; r0_fec = ~fec; r1_fec = ~fec; r0_aux = ~aux; r1_aux = ~aux;
    checkOutput("setup_psel", 32'(psel_tx), 1);
    checkOutput("setup_penable", 32'(penable_tx), 0);
    checkOutput("setup_pwrite", 32'(pwrite_tx), 1);
    checkOutput("setup_pwdata", 32'(pwdata_tx), 32'(data));
    checkOutput("setup_fec", 32'(fec_out), 32'(fec));
    checkOutput("setup_aux", 32'(aux_out), 32'(aux));
    checkOutput("setup_grant", 32'(grant_id), 32'(expGrant));
    checkOutput("setup_busy", 32'(busy), 1);
    @(posedge txclk); #1;
    checkOutput("access_psel", 32'(psel_tx), 1);
    checkOutput("access_penable", 32'(penable_tx), 1);
    checkOutput("access_pwdata", 32'(pwdata_tx), 32'(data));
    @(posedge txclk); #1;
    expCnt = expCnt + CNT_W'(1);
    checkOutput("done_psel", 32'(psel_tx), 0);
    checkOutput("done_penable", 32'(penable_tx), 0);
    checkOutput("done_pwrite", 32'(pwrite_tx), 0);
    checkOutput("done_busy", 32'(busy), 0);
    checkOutput("done_hold_pwdata", 32'(pwdata_tx), 32'(data));
    checkOutput("done_hold_fec", 32'(fec_out), 32'(fec));
    checkOutput("done_timeout_err", 32'(timeout_err), 0);
    checkOutput("done_xfer_cnt", 32'(xfer_cnt), 32'(expCnt));
  endtask

  // Main directed sequence.
  initial begin
    logic [DATA_W-1:0] wordsA[2];
    logic [DATA_W-1:0] wordsB[2];
    logic [DATA_W-1:0] logData[$];
    logic              logGrant[$];
    int                logCycle[$];
    int                idx0, idx1, accessLen, errPulses;
    logic              acc0, acc1;

    arbTab[0] = '{en: 1'b0, v0: 1'b1, v1: 1'b1, expR0: 1'b0, expR1: 1'b0};
    arbTab[1] = '{en: 1'b1, v0: 1'b0, v1: 1'b0, expR0: 1'b0, expR1: 1'b0};
    arbTab[2] = '{en: 1'b1, v0: 1'b1, v1: 1'b0, expR0: 1'b1, expR1: 1'b0};
    arbTab[3] = '{en: 1'b1, v0: 1'b0, v1: 1'b1, expR0: 1'b0, expR1: 1'b1};
    arbTab[4] = '{en: 1'b1, v0: 1'b1, v1: 1'b1, expR0: 1'b1, expR1: 1'b0};
    arbTab[5] = '{en: 1'b0, v0: 1'b0, v1: 1'b1, expR0: 1'b0, expR1: 1'b0};

    xferTab[0] = '{req: 1'b0, data: 16'h1234, fec: 1'b1, aux: 1'b0, expGrant: 1'b0};
    xferTab[1] = '{req: 1'b1, data: 16'hABCD, fec: 1'b0, aux: 1'b1, expGrant: 1'b1};
    xferTab[2] = '{req: 1'b1, data: 16'h5A5A, fec: 1'b1, aux: 1'b1, expGrant: 1'b1};
    xferTab[3] = '{req: 1'b0, data: 16'h0F0F, fec: 1'b0, aux: 1'b0, expGrant: 1'b0};

    // Reset values, sampled while reset is still asserted.
    presetn = 1'b0;
    #3;
    checkOutput("rst_psel", 32'(psel_tx), 0);
    checkOutput("rst_penable", 32'(penable_tx), 0);
    checkOutput("rst_pwrite", 32'(pwrite_tx), 0);
    checkOutput("rst_pwdata", 32'(pwdata_tx), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_grant", 32'(grant_id), 0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 0);
    checkOutput("rst_xfer_cnt", 32'(xfer_cnt), 0);

    // Arbitration table: readies only, valids withdrawn before each edge so nothing is accepted.
    doReset();
    for (int i = 0; i < 6; i++) begin
      enable = arbTab[i].en; r0_valid = arbTab[i].v0; r1_valid = arbTab[i].v1;
      #1;
      checkOutput($sformatf("arb%0d_r0_ready", i), 32'(r0_ready), 32'(arbTab[i].expR0));
      checkOutput($sformatf("arb%0d_r1_ready", i), 32'(r1_ready), 32'(arbTab[i].expR1));
      checkOutput($sformatf("arb%0d_busy", i), 32'(busy), 0);
      r0_valid = 1'b0; r1_valid = 1'b0;
      @(posedge txclk); #1;
    end
    enable = 1'b1;

    // Transfer table: single-requester words with pready tied high.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(xferTab[i].req, xferTab[i].data, xferTab[i].fec, xferTab[i].aux, xferTab[i].expGrant);
    end

    // Both requesters streaming: expect A0,B0,A1,B1 one word every 3 cycles.
    doReset();
    wordsA[0] = 16'hA000; wordsA[1] = 16'hA001;
    wordsB[0] = 16'hB000; wordsB[1] = 16'hB001;
    idx0 = 0; idx1 = 0;
    r0_valid = 1'b1; r0_data = wordsA[0];
    r1_valid = 1'b1; r1_data = wordsB[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge txclk);
      acc0 = r0_ready; acc1 = r1_ready;
      if (psel_tx && penable_tx && pready) begin
        logData.push_back(pwdata_tx);
        logGrant.push_back(grant_id);
        logCycle.push_back(c);
      end
      @(posedge txclk); #1;
      if (acc0) begin
        idx0++;
        if (idx0 >= 2) r0_valid = 1'b0; else r0_data = wordsA[idx0];
      end
      if (acc1) begin
        idx1++;
        if (idx1 >= 2) r1_valid = 1'b0; else r1_data = wordsB[idx1];
      end
    end
    checkOutput("rr_count", 32'(logData.size()), 4);
    if (logData.size() == 4) begin
      checkOutput("rr_word0", 32'(logData[0]), 32'hA000);
      checkOutput("rr_word1", 32'(logData[1]), 32'hB000);
      checkOutput("rr_word2", 32'(logData[2]), 32'hA001);
      checkOutput("rr_word3", 32'(logData[3]), 32'hB001);
      checkOutput("rr_grant0", 32'(logGrant[0]), 0);
      checkOutput("rr_grant1", 32'(logGrant[1]), 1);
      checkOutput("rr_grant2", 32'(logGrant[2]), 0);
      checkOutput("rr_grant3", 32'(logGrant[3]), 1);
      for (int k = 1; k < 4; k++) begin
        checkOutput($sformatf("rr_spacing%0d", k), 32'(logCycle[k] - logCycle[k-1]), 3);
      end
    end
    checkOutput("rr_xfer_cnt", 32'(xfer_cnt), 4);

    // Timeout: pready held low for the whole ACCESS phase.
    doReset();
    pready = 1'b0;
    r0_valid = 1'b1; r0_data = 16'h7777;
    @(posedge txclk); #1;
    r0_valid = 1'b0;
    checkOutput("to_setup_psel", 32'(psel_tx && !penable_tx), 1);
    accessLen = 0; errPulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge txclk); #1;
      if (timeout_err) errPulses++;
      if (!penable_tx) break;
      accessLen++;
    end
    checkOutput("to_access_len", 32'(accessLen), 16);
    checkOutput("to_err_now", 32'(timeout_err), 1);
    checkOutput("to_psel_low", 32'(psel_tx), 0);
    checkOutput("to_busy_low", 32'(busy), 0);
    @(posedge txclk); #1;
    if (timeout_err) errPulses++;
    checkOutput("to_err_pulses", 32'(errPulses), 1);
    checkOutput("to_xfer_cnt", 32'(xfer_cnt), 0);

    // pready arriving in the last allowed ACCESS cycle still succeeds.
    doReset();
    pready = 1'b0;
    r0_valid = 1'b1; r0_data = 16'h8888;
    @(posedge txclk); #1;
    r0_valid = 1'b0;
    accessLen = 0; errPulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge txclk); #1;
      if (timeout_err) errPulses++;
      if (!penable_tx) break;
      accessLen++;
      if (accessLen == 16) pready = 1'b1;
    end
    @(posedge txclk); #1;
    if (timeout_err) errPulses++;
    checkOutput("late_access_len", 32'(accessLen), 16);
    checkOutput("late_err_pulses", 32'(errPulses), 0);
    checkOutput("late_xfer_cnt", 32'(xfer_cnt), 1);

    // Reset during ACCESS drops the strobes without a clock edge.
    doReset();
    pready = 1'b0;
    r0_valid = 1'b1; r0_data = 16'h9999;
    @(posedge txclk); #1;
    r0_valid = 1'b0;
    @(posedge txclk); #1;
    @(posedge txclk); #1;
    checkOutput("midrst_pre_penable", 32'(penable_tx), 1);
    #2;
    presetn = 1'b0;
    #1;
    checkOutput("midrst_psel", 32'(psel_tx), 0);
    checkOutput("midrst_penable", 32'(penable_tx), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_xfer_cnt", 32'(xfer_cnt), 0);
    @(posedge txclk); #1;
    presetn = 1'b1;
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    checkOutput("midrst_r0_first", 32'(r0_ready), 1);
    checkOutput("midrst_r1_blocked", 32'(r1_ready), 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(posedge txclk); #1;

    // enable low blocks grants; dropping it mid-transfer lets that transfer finish.
    doReset();
    enable = 1'b0;
    r1_valid = 1'b1; r1_data = 16'hC0DE;
    for (int c = 0; c < 3; c++) begin
      @(posedge txclk); #1;
      checkOutput("en_low_r1_ready", 32'(r1_ready), 0);
      checkOutput("en_low_busy", 32'(busy), 0);
    end
    enable = 1'b1;
    #1;
    checkOutput("en_high_r1_ready", 32'(r1_ready), 1);
    @(posedge txclk); #1;
    r1_valid = 1'b0; enable = 1'b0; r0_valid = 1'b1; r0_data = 16'hDEAD;
    checkOutput("en_drop_busy", 32'(busy), 1);
    @(posedge txclk); #1;
    checkOutput("en_drop_penable", 32'(penable_tx), 1);
    @(posedge txclk); #1;
    checkOutput("en_drop_xfer_cnt", 32'(xfer_cnt), 1);
    checkOutput("en_drop_pwdata", 32'(pwdata_tx), 32'hC0DE);
    for (int c = 0; c < 3; c++) begin
      checkOutput("en_drop_no_grant", 32'(r0_ready), 0);
      checkOutput("en_drop_idle", 32'(busy), 0);
      @(posedge txclk); #1;
    end
    r0_valid = 1'b0; enable = 1'b1;

    // Counter wrap: 2^CNT_W completions return xfer_cnt to zero.
    doReset();
    for (int n = 0; n < 15; n++) begin
      applyStimulus(1'(n % 2), 16'(16'h4000 + n), 1'b0, 1'b1, 1'(n % 2));
    end
    checkOutput("wrap_at_max", 32'(xfer_cnt), 15);
    applyStimulus(1'b1, 16'h4FFF, 1'b1, 1'b0, 1'b1);
    checkOutput("wrap_to_zero", 32'(xfer_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bow_tx_apb_arbiter.md
Name: bow_tx_apb_arbiter

Overview:
- Round-robin arbiter and APB master sequencer for the BoW transmit APB port (psel/penable/pwrite/pwdata plus fec/aux sidebands).
- Shares the single TX APB interface between two requesters, e.g. the link-layer data path and the config/aux path.
- Runs each accepted word through a full APB setup/access cycle, waits for pready, and aborts on timeout.
- Sits between the requester logic and the BoW system TX inputs, clocked by txclk.

Parameters:
DATA_W, 16, width of the data word and pwdata.
TIMEOUT, 16, max ACCESS-phase cycles waiting for pready before abort (legal range 1..255).
CNT_W, 16, width of the completed-transfer counter.

Ports:
txclk  in  1  system clock, all logic on the rising edge.
presetn  in  1  asynchronous active-low reset.
enable  in  1  when low, no new grants are issued; an in-flight transfer still completes.
r0_valid  in  1  requester 0 has a word.
r0_ready  out  1  requester 0 word accepted this cycle.
r0_data  in  DATA_W  requester 0 word.
r0_fec  in  1  requester 0 FEC sideband.
r0_aux  in  1  requester 0 AUX sideband.
r1_valid, r1_ready, r1_data, r1_fec, r1_aux  as above, for requester 1.
psel_tx  out  1  APB select.
penable_tx  out  1  APB enable.
pwrite_tx  out  1  APB write; high whenever psel_tx is high.
pwdata_tx  out  DATA_W  APB write data.
fec_out  out  1  FEC sideband for the transfer in flight.
aux_out  out  1  AUX sideband for the transfer in flight.
pready  in  1  APB completer ready.
busy  out  1  FSM not in IDLE.
grant_id  out  1  requester owning the current or last transfer.
timeout_err  out  1  one-cycle pulse on abort.
xfer_cnt  out  CNT_W  count of completed (pready) transfers.

Behaviour:
- Async reset, while presetn is low:
  - All outputs 0 and state IDLE.
  - last_grant=1, so requester 0 wins the first arbitration.
  - Reset mid-transfer drops psel_tx/penable_tx immediately; the word is lost and xfer_cnt is not incremented.
- FSM states: IDLE, SETUP, ACCESS. All APB and sideband outputs are registered; rN_ready is combinational.
- IDLE, arbitration:
  - pick = the requester other than last_grant if it is valid, else the valid one.
  - rN_ready = enable && state==IDLE && rN_valid && pick==N; at most one ready is high in any cycle.
- IDLE, on a clock edge where rN_valid && rN_ready:
  - Latch rN_data/fec/aux into pwdata_tx/fec_out/aux_out.
  - Set grant_id=N and last_grant=N.
  - Next state SETUP.
- SETUP, one cycle: psel_tx=1, pwrite_tx=1, penable_tx=0. Next state ACCESS.
- ACCESS:
  - psel_tx=1, penable_tx=1; wait counter starts at 0 and increments each cycle.
  - pready=1 sampled at an edge: transfer completes, xfer_cnt+1, next state IDLE.
  - No pready by the TIMEOUT-th ACCESS cycle: timeout_err pulses 1 cycle, xfer_cnt unchanged, next state IDLE.
  - pready at that same edge wins over the timeout (counts as success, no error).
- Return to IDLE: psel_tx/penable_tx/pwrite_tx go to 0. pwdata_tx/fec_out/aux_out hold their last value.
- Latency and throughput:
  - Accept to psel_tx rising: 1 cycle.
  - Minimum transfer (pready held high) = 3 cycles per word: IDLE accept, SETUP, ACCESS.
- pready outside ACCESS is ignored.
- xfer_cnt wraps from 2^CNT_W-1 to 0.
- enable deasserted during SETUP/ACCESS does not stop the transfer. It only blocks the next acceptance in IDLE.
- Requester inputs may change freely after their handshake; only the latched copy is driven.
- busy = (state != IDLE).

Test Plan:
- Reset, then r0 sends 0x1234 with fec=1 and pready tied high → psel_tx up 1 cycle after accept; penable_tx up the next cycle with pwdata_tx=0x1234, fec_out=1; xfer_cnt=1; r1 never ready.
- Both requesters valid continuously, words A0,A1 / B0,B1, pready high → APB order A0,B0,A1,B1; grant_id alternates 0,1,0,1; one word every 3 cycles; xfer_cnt=4.
- pready held low, TIMEOUT=16 → ACCESS lasts 16 cycles, timeout_err pulses once, xfer_cnt stays 0. Repeat with pready rising on cycle 16 → success, no error.
- presetn asserted during ACCESS → psel_tx/penable_tx 0 without waiting for a clock edge. After release, requester 0 wins the first grant.
- enable low with r1_valid high → no ready, busy=0. Drop enable during an in-flight transfer → it completes and no new grant is issued.
- Preload xfer_cnt near max: 0xFFFF completions plus one → xfer_cnt wraps to 0x0000.
